// File: rtl/aes_req_sequencer_if.sv
// ---------------------------------------------------------------------------
// aes_req_sequencer_if
//
// Request/response handshake bundle between a caller and aes_req_sequencer.
//
//   Request channel (caller -> sequencer)
//     req_valid  request present
//     req_ready  sequencer FIFO can take the request
//     req_func   1=encrypt, 2=decrypt, 3=encrypt with new key schedule, 0=illegal
//     req_text   plaintext (func[0]=1) or ciphertext (func[0]=0)
//     req_key    cipher key
//     req_tag    caller tag, returned with the response
//
//   Response channel (sequencer -> caller)
//     res_valid  response present
//     res_ready  caller accepts the response
//     res_data   result block (0 when res_err=1)
//     res_tag    tag of the originating request
//     res_err    illegal func or aborted operation
//
// Modports: master = caller side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface aes_req_sequencer_if #(
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_func;
  logic [127:0]     req_text;
  logic [127:0]     req_key;
  logic [TAG_W-1:0] req_tag;

  logic             res_valid;
  logic             res_ready;
  logic [127:0]     res_data;
  logic [TAG_W-1:0] res_tag;
  logic             res_err;

  modport master (
    output req_valid, req_func, req_text, req_key, req_tag,
    input  req_ready,
    input  res_valid, res_data, res_tag, res_err,
    output res_ready
  );

  modport slave (
    input  req_valid, req_func, req_text, req_key, req_tag,
    output req_ready,
    output res_valid, res_data, res_tag, res_err,
    input  res_ready
  );
endinterface

// File: rtl/aes_req_sequencer.sv
// ---------------------------------------------------------------------------
// aes_req_sequencer
//
// Command stage in front of aes_build. Requests are buffered in a DEPTH-entry
// FIFO; one at a time is handed to aes_build with its inputs held stable until
// call_complete, and the selected result is returned with the caller's tag.
//
// Parameters
//   DEPTH    FIFO entries (power of 2, >= 2)
//   TAG_W    caller tag width
//   TIMEOUT  RUN-cycle limit before abort (watchdog builds only, >= 2)
//
// Ports
//   eph1           clock, all state changes on its rising edge
//   reset          synchronous, active-high
//   bus            request/response handshake (aes_req_sequencer_if.slave)
//   aes_func       to aes_build.func, 0 = idle
//   aes_text       to aes_build.text_in
//   aes_key        to aes_build.true_key
//   call_complete  from aes_build, result valid this cycle
//   ciphertext     from aes_build
//   plaintext      from aes_build
//   busy           FSM not idle or FIFO non-empty
//   fifo_count     occupied FIFO entries
//
// Build option
//   AES_SEQ_TIMEOUT_EN  when defined, a RUN-cycle watchdog aborts an operation
//                       that has not completed after TIMEOUT cycles; the
//                       response then carries res_err=1 and res_data=0.
// ---------------------------------------------------------------------------
module aes_req_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                       eph1,
  input  logic                       reset,
  aes_req_sequencer_if.slave         bus,
  output logic [1:0]                 aes_func,
  output logic [127:0]               aes_text,
  output logic [127:0]               aes_key,
  input  logic                       call_complete,
  input  logic [127:0]               ciphertext,
  input  logic [127:0]               plaintext,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int ENT_W = 2 + 128 + 128 + TAG_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [ENT_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic [1:0]       state;
  logic             push;
  logic             pop;
  logic             run_expired;

  logic [1:0]       head_func;
  logic [127:0]     head_text;
  logic [127:0]     head_key;
  logic [TAG_W-1:0] head_tag;

  // Only func[0] matters once running: it picks ciphertext vs plaintext.
  logic             cur_enc;
  logic [TAG_W-1:0] cur_tag;

  logic             res_valid_q;
  logic [127:0]     res_data_q;
  logic [TAG_W-1:0] res_tag_q;
  logic             res_err_q;

  // No full bypass: a pop in the same cycle never makes room for a push.
  assign bus.req_ready = (count < CNT_W'(DEPTH));
  assign push          = bus.req_valid && bus.req_ready;
  assign pop           = (state == ST_IDLE) && (count != '0);

  assign {head_func, head_text, head_key, head_tag} = fifo_mem[rd_ptr];

  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_tag   = res_tag_q;
  assign bus.res_err   = res_err_q;

  assign busy          = (state != ST_IDLE) || (count != '0);
  assign fifo_count    = count;

  // ---- FIFO storage: payload only, contents are don't-care while empty ----
  always_ff @(posedge eph1) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {bus.req_func, bus.req_text, bus.req_key, bus.req_tag};
    end
  end

`ifdef AES_SEQ_TIMEOUT_EN
  localparam int                TCNT_W = $clog2(TIMEOUT);
  localparam logic [TCNT_W-1:0] TLAST  = TCNT_W'(TIMEOUT - 1);

  logic [TCNT_W-1:0] run_cnt;

  // ---- RUN watchdog: held at zero outside RUN, so every RUN entry starts at 0 ----
  always_ff @(posedge eph1) begin
    if (reset || (state != ST_RUN)) begin
      run_cnt <= '0;
    end else begin
      run_cnt <= run_cnt + 1'b1;
    end
  end

  assign run_expired = (state == ST_RUN) && (run_cnt == TLAST);
`else
  // TIMEOUT only matters when the watchdog is built in.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT < 2);
  assign run_expired    = 1'b0;
`endif

  // ---- Control: pointers, occupancy, FSM, aes_build drive, response ----
  always_ff @(posedge eph1) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      state       <= ST_IDLE;
      aes_func    <= 2'd0;
      aes_text    <= '0;
      aes_key     <= '0;
      cur_enc     <= 1'b0;
      cur_tag     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_tag_q   <= '0;
      res_err_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case (state)
        ST_IDLE: begin
          if (pop) begin
            if (head_func != 2'd0) begin
              aes_func <= head_func;
              aes_text <= head_text;
              aes_key  <= head_key;
              cur_enc  <= head_func[0];
              cur_tag  <= head_tag;
              state    <= ST_RUN;
            end else begin
              // Illegal func: answer with an error without starting aes_build.
              res_valid_q <= 1'b1;
              res_err_q   <= 1'b1;
              res_data_q  <= '0;
              res_tag_q   <= head_tag;
              state       <= ST_RESP;
            end
          end
        end

        ST_RUN: begin
          // Completion takes priority over a watchdog expiry in the same cycle.
          if (call_complete) begin
            res_valid_q <= 1'b1;
            res_err_q   <= 1'b0;
            res_data_q  <= cur_enc ? ciphertext : plaintext;
            res_tag_q   <= cur_tag;
            aes_func    <= 2'd0;
            state       <= ST_RESP;
          end else if (run_expired) begin
            res_valid_q <= 1'b1;
            res_err_q   <= 1'b1;
            res_data_q  <= '0;
            res_tag_q   <= cur_tag;
            aes_func    <= 2'd0;
            state       <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_req_sequencer.sv
// ---------------------------------------------------------------------------
// tb_aes_req_sequencer
//
// Bench for aes_req_sequencer. A behavioural aes_build stub answers RUN
// operations after a programmable delay: the FIPS-197 example block maps to
// its known result, any other block maps to text^key (encrypt) or
// text^~key (decrypt). Expected responses are queued when a request is issued
// and popped by an independent monitor on every response handshake.
// ---------------------------------------------------------------------------
module tb_aes_req_sequencer;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
`ifdef AES_SEQ_TIMEOUT_EN
  localparam int TIMEOUT = 8;
`else
  localparam int TIMEOUT = 64;
`endif
  localparam int CNT_W = $clog2(DEPTH+1);

  localparam logic [127:0] K_FIPS  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_FIPS = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K_MISC  = 128'hfedcba98765432100123456789abcdef;

  logic             eph1;
  logic             reset;
  logic [1:0]       aes_func;
  logic [127:0]     aes_text;
  logic [127:0]     aes_key;
  logic             call_complete;
  logic [127:0]     ciphertext;
  logic [127:0]     plaintext;
  logic             busy;
  logic [CNT_W-1:0] fifo_count;

  aes_req_sequencer_if #(.TAG_W(TAG_W)) bus ();

  aes_req_sequencer #(
    .DEPTH   (DEPTH),
    .TAG_W   (TAG_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .eph1          (eph1),
    .reset         (reset),
    .bus           (bus),
    .aes_func      (aes_func),
    .aes_text      (aes_text),
    .aes_key       (aes_key),
    .call_complete (call_complete),
    .ciphertext    (ciphertext),
    .plaintext     (plaintext),
    .busy          (busy),
    .fifo_count    (fifo_count)
  );

  typedef struct packed {
    logic [127:0]     data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic stub_en;
  int   stub_delay;
  logic late_cc;

  initial eph1 = 1'b0;
  always #5 eph1 = ~eph1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic bound_expired(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got cycle budget exhausted, expected DUT event", name);
  endtask

  function automatic logic [127:0] stub_ct(input logic [127:0] t, input logic [127:0] k);
    return (k == K_FIPS && t == PT_FIPS) ? CT_FIPS : (t ^ k);
  endfunction

  function automatic logic [127:0] stub_pt(input logic [127:0] t, input logic [127:0] k);
    return (k == K_FIPS && t == CT_FIPS) ? PT_FIPS : (t ^ ~k);
  endfunction

  task automatic expect_resp(input logic [127:0] d, input logic [TAG_W-1:0] tg, input logic e);
    exp_t x;
    x.data = d;
    x.tag  = tg;
    x.err  = e;
    exp_q.push_back(x);
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [1:0] f, input logic [127:0] t, input logic [127:0] k,
                      input logic [TAG_W-1:0] tg);
    int   guard;
    logic rdy;
    guard = 0;
    bus.req_valid = 1'b1;
    bus.req_func  = f;
    bus.req_text  = t;
    bus.req_key   = k;
    bus.req_tag   = tg;
    forever begin
      @(negedge eph1);
      rdy = bus.req_ready;
      @(posedge eph1);
      #1;
      if (rdy) break;
      guard++;
      if (guard > 200) begin
        bound_expired("send_accept");
        break;
      end
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while ((exp_q.size() != 0 || busy) && g < 400) begin
      @(posedge eph1);
      #1;
      g++;
    end
    if (g >= 400) bound_expired(name);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge eph1);
      #1;
    end
  endtask

  // ---- aes_build stub ----
  initial begin
    int cnt;
    cnt           = 0;
    call_complete = 1'b0;
    ciphertext    = '0;
    plaintext     = '0;
    forever begin
      @(posedge eph1);
      #1;
      call_complete = late_cc;
      if (stub_en && aes_func != 2'd0) begin
        if (cnt >= stub_delay) begin
          call_complete = 1'b1;
          ciphertext    = stub_ct(aes_text, aes_key);
          plaintext     = stub_pt(aes_text, aes_key);
          cnt           = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // ---- Response monitor ----
  initial begin
    exp_t e;
    forever begin
      @(negedge eph1);
      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_response_tag", 128'(bus.res_tag), 128'hffff_ffff);
        end else begin
          e = exp_q.pop_front();
          check("res_data", bus.res_data, e.data);
          check("res_tag", 128'(bus.res_tag), 128'(e.tag));
          check("res_err", 128'(bus.res_err), 128'(e.err));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected bench to finish");
    $fatal(1, "bench watchdog expired");
  end

  // ---- Directed sequence ----
  initial begin
    logic [127:0] t;
    logic [1:0]   f;
    int           cyc;
    logic         seen;

    reset         = 1'b1;
    stub_en       = 1'b1;
    stub_delay    = 3;
    late_cc       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_func  = 2'd0;
    bus.req_text  = '0;
    bus.req_key   = '0;
    bus.req_tag   = '0;
    bus.res_ready = 1'b0;
    tick(3);

    // Reset state
    check("rst_aes_func",   128'(aes_func), 128'd0);
    check("rst_aes_text",   aes_text, 128'd0);
    check("rst_aes_key",    aes_key, 128'd0);
    check("rst_res_valid",  128'(bus.res_valid), 128'd0);
    check("rst_res_data",   bus.res_data, 128'd0);
    check("rst_res_tag",    128'(bus.res_tag), 128'd0);
    check("rst_res_err",    128'(bus.res_err), 128'd0);
    check("rst_busy",       128'(busy), 128'd0);
    check("rst_fifo_count", 128'(fifo_count), 128'd0);
    check("rst_req_ready",  128'(bus.req_ready), 128'd1);
    reset = 1'b0;
    tick(1);

    // T1 encrypt with latency of issue to aes_build
    bus.res_ready = 1'b1;
    expect_resp(CT_FIPS, 4'd5, 1'b0);
    send(2'd1, PT_FIPS, K_FIPS, 4'd5);
    check("t1_count_after_push", 128'(fifo_count), 128'd1);
    check("t1_func_before_pop",  128'(aes_func), 128'd0);
    tick(1);
    check("t1_aes_func", 128'(aes_func), 128'd1);
    check("t1_aes_text", aes_text, PT_FIPS);
    check("t1_aes_key",  aes_key, K_FIPS);
    check("t1_count_after_pop", 128'(fifo_count), 128'd0);
    check("t1_busy", 128'(busy), 128'd1);
    drain("t1_drain");

    // T2 decrypt
    expect_resp(PT_FIPS, 4'd6, 1'b0);
    send(2'd2, CT_FIPS, K_FIPS, 4'd6);
    drain("t2_drain");

    // T3 fill with the consumer stalled
    bus.res_ready = 1'b0;
    stub_delay    = 2;
    for (int i = 0; i <= DEPTH; i++) begin
      f = 2'((i % 3) + 1);
      t = {4{32'(32'h1000_0000 + i)}};
      expect_resp(f[0] ? (t ^ K_MISC) : (t ^ ~K_MISC), TAG_W'(i), 1'b0);
      send(f, t, K_MISC, TAG_W'(i));
    end
    tick(6);
    check("t3_full_count",     128'(fifo_count), 128'(DEPTH));
    check("t3_full_req_ready", 128'(bus.req_ready), 128'd0);
    check("t3_resp_waiting",   128'(bus.res_valid), 128'd1);
    // An extra request while full must be refused (the monitor flags it if not).
    bus.req_valid = 1'b1;
    bus.req_func  = 2'd1;
    bus.req_text  = 128'hdead;
    bus.req_key   = K_MISC;
    bus.req_tag   = 4'd9;
    tick(3);
    bus.req_valid = 1'b0;
    check("t3_refused_count", 128'(fifo_count), 128'(DEPTH));
    bus.res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge eph1);
      if (fifo_count == CNT_W'(DEPTH)) check("t3_no_bypass_ready", 128'(bus.req_ready), 128'd0);
    end
    @(posedge eph1);
    #1;
    drain("t3_drain");

    // T4 illegal func
    expect_resp(128'd0, 4'd3, 1'b1);
    send(2'd0, 128'h1234_5678, K_MISC, 4'd3);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (aes_func != 2'd0) seen = 1'b1;
      tick(1);
    end
    check("t4_aes_func_stays_0", 128'(seen), 128'd0);
    drain("t4_drain");

    // T5 reset while an op is running and another is queued
    stub_en = 1'b0;
    send(2'd1, 128'h77, K_MISC, 4'd7);
    send(2'd2, 128'h88, K_MISC, 4'd8);
    check("t5_running", 128'(aes_func), 128'd1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("t5_aes_func", 128'(aes_func), 128'd0);
    check("t5_count",    128'(fifo_count), 128'd0);
    check("t5_res_valid", 128'(bus.res_valid), 128'd0);
    check("t5_busy",     128'(busy), 128'd0);
    late_cc = 1'b1;
    seen    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (bus.res_valid) seen = 1'b1;
    end
    late_cc = 1'b0;
    tick(2);
    if (bus.res_valid) seen = 1'b1;
    check("t5_late_complete_ignored", 128'(seen), 128'd0);

    // Recovery after reset
    stub_en    = 1'b1;
    stub_delay = 1;
    expect_resp(CT_FIPS, 4'd1, 1'b0);
    send(2'd3, PT_FIPS, K_FIPS, 4'd1);
    drain("recover_drain");

`ifdef AES_SEQ_TIMEOUT_EN
    // T6 watchdog expiry, then completion on the expiry cycle
    stub_en = 1'b0;
    expect_resp(128'd0, 4'd10, 1'b1);
    send(2'd1, 128'h5555, K_MISC, 4'd10);
    cyc = 0;
    while (aes_func == 2'd0 && cyc < 50) begin
      tick(1);
      cyc++;
    end
    cyc = 0;
    while (!bus.res_valid && cyc < 50) begin
      tick(1);
      cyc++;
    end
    check("t6_timeout_cycles", 128'(cyc), 128'd8);
    drain("t6a_drain");

    stub_en    = 1'b1;
    stub_delay = 7;
    expect_resp(128'h6666 ^ K_MISC, 4'd11, 1'b0);
    send(2'd3, 128'h6666, K_MISC, 4'd11);
    cyc = 0;
    while (aes_func == 2'd0 && cyc < 50) begin
      tick(1);
      cyc++;
    end
    cyc = 0;
    while (!bus.res_valid && cyc < 50) begin
      tick(1);
      cyc++;
    end
    check("t6_complete_cycles", 128'(cyc), 128'd8);
    drain("t6b_drain");
`else
    // Without the watchdog a slow aes_build is simply waited for.
    stub_delay = 80;
    expect_resp(128'h4242 ^ ~K_MISC, 4'd12, 1'b0);
    send(2'd2, 128'h4242, K_MISC, 4'd12);
    cyc = 0;
    while (!bus.res_valid && cyc < 200) begin
      tick(1);
      cyc++;
    end
    check("slow_op_cycles", 128'(cyc), 128'd82);
    drain("slow_drain");
`endif

    tick(2);
    check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
